// File: rtl/keypad_pkg.sv
// Shared key codes, operator encoding and qualifier state type for the keypad path.
package keypad_pkg;

  localparam logic [3:0] KEY_MAX_DIGIT = 4'h9;
  localparam logic [3:0] KEY_A         = 4'hA;
  localparam logic [3:0] KEY_B         = 4'hB;
  localparam logic [3:0] KEY_C         = 4'hC;
  localparam logic [3:0] KEY_STAR      = 4'hD;
  localparam logic [3:0] KEY_HASH      = 4'hE;
  localparam logic [3:0] KEY_NONE      = 4'hF;

  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_A    = 2'd1;
  localparam logic [1:0] OP_B    = 2'd2;
  localparam logic [1:0] OP_C    = 2'd3;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_QUAL   = 2'd1,
    ACCEPT       = 2'd2,
    RELEASE_QUAL = 2'd3
  } qual_state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= KEY_MAX_DIGIT;
  endfunction

  function automatic logic [1:0] op_code(input logic [3:0] code);
    logic [1:0] sel;
    case (code)
      KEY_A:   sel = OP_A;
      KEY_B:   sel = OP_B;
      KEY_C:   sel = OP_C;
      default: sel = OP_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/key_qualifier.sv
// Turns the raw key code stream into one event per stable press, with a stable
// release required before the next press is considered.
//
// state        | meaning
// -------------+------------------------------------------------------------
// IDLE         | armed, waiting for any key on code_q
// PRESS_QUAL   | counting consecutive cycles of the captured candidate
// ACCEPT       | one-cycle event; key_event high, key_val = candidate
// RELEASE_QUAL | counting consecutive no-key cycles before re-arming
module key_qualifier
  import keypad_pkg::*;
#(
  parameter int STABLE_CYCLES = 27_000
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic [3:0] key_code,
  output logic       key_event,
  output logic [3:0] key_val
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  qual_state_t   state, state_next;
  logic [3:0]    code_q;
  logic [3:0]    cand, cand_next;
  logic [CW-1:0] cnt, cnt_next;

  // Input register, state, candidate and counter registers.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      code_q <= KEY_NONE;
      state  <= IDLE;
      cand   <= KEY_NONE;
      cnt    <= '0;
    end else begin
      code_q <= key_code;
      state  <= state_next;
      cand   <= cand_next;
      cnt    <= cnt_next;
    end
  end

  // Next-state and counter logic; the counter only runs up to CNT_LAST, so it never wraps.
  always_comb begin
    state_next = state;
    cand_next  = cand;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (code_q != KEY_NONE) begin
          cand_next = code_q;
          // With a one-cycle window the capture cycle alone qualifies the press.
          if (STABLE_CYCLES == 1) begin
            state_next = ACCEPT;
            cnt_next   = '0;
          end else begin
            state_next = PRESS_QUAL;
            cnt_next   = CW'(1);
          end
        end
      end
      PRESS_QUAL: begin
        if (code_q != cand) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = ACCEPT;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      ACCEPT: begin
        state_next = RELEASE_QUAL;
        cnt_next   = '0;
      end
      RELEASE_QUAL: begin
        if (code_q != KEY_NONE) begin
          cnt_next = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign key_event = (state == ACCEPT);
  assign key_val   = cand;

endmodule

// File: rtl/key_entry.sv
// Keypad entry: qualified key events drive a BCD operand accumulator and
// one-cycle operator / clear / enter pulses.
module key_entry
  import keypad_pkg::*;
#(
  parameter int NUM_DIGITS    = 3,
  parameter int STABLE_CYCLES = 27_000
) (
  input  logic                            clk,
  input  logic                            n_reset,
  input  logic [3:0]                      key_code,
  output logic [4*NUM_DIGITS-1:0]         operand_bcd,
  output logic [$clog2(NUM_DIGITS+1)-1:0] digit_count,
  output logic                            operand_valid,
  output logic                            op_valid,
  output logic [1:0]                      op_sel,
  output logic                            clear_pulse
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(NUM_DIGITS + 1);

  logic          key_event;
  logic [3:0]    key_val;
  logic [DW-1:0] operand_q, operand_next, shifted;
  logic [CW-1:0] count_q, count_next;
  logic [1:0]    op_sel_q, op_sel_next;

  key_qualifier #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_qual (
    .clk      (clk),
    .n_reset  (n_reset),
    .key_code (key_code),
    .key_event(key_event),
    .key_val  (key_val)
  );

  // Accumulator and latched operator registers; they change on the edge ending ACCEPT.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      operand_q <= '0;
      count_q   <= '0;
      op_sel_q  <= OP_NONE;
    end else begin
      operand_q <= operand_next;
      count_q   <= count_next;
      op_sel_q  <= op_sel_next;
    end
  end

  // Action decode; pulses come straight from the registered event so they share the ACCEPT cycle.
  always_comb begin
    operand_next  = operand_q;
    count_next    = count_q;
    op_sel_next   = op_sel_q;
    operand_valid = 1'b0;
    op_valid      = 1'b0;
    clear_pulse   = 1'b0;
    shifted       = operand_q << 4;
    shifted[3:0]  = key_val;
    if (key_event) begin
      case (key_val)
        KEY_A, KEY_B, KEY_C: begin
          op_valid    = 1'b1;
          op_sel_next = op_code(key_val);
        end
        KEY_STAR: begin
          clear_pulse  = 1'b1;
          operand_next = '0;
          count_next   = '0;
        end
        KEY_HASH: begin
          // Present the value during the pulse, then clear for the next entry.
          if (count_q != '0) begin
            operand_valid = 1'b1;
            operand_next  = '0;
            count_next    = '0;
          end
        end
        default: begin
          // A full operand silently drops further digits.
          if (is_digit(key_val) && (count_q < CW'(NUM_DIGITS))) begin
            operand_next = shifted;
            count_next   = count_q + CW'(1);
          end
        end
      endcase
    end
  end

  assign operand_bcd = operand_q;
  assign digit_count = count_q;
  // The new operator is already visible alongside its op_valid pulse.
  assign op_sel      = op_valid ? op_sel_next : op_sel_q;

endmodule
